// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state encodings and flag bit positions for seq_alu.
package alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_NAND = 3'b001,
        OP_BNZ  = 3'b010,
        OP_SLTU = 3'b011,
        OP_SUB  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    function automatic logic [3:0] pack_flags(input logic n, input logic v, input logic c, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction
endpackage

// File: rtl/alu_mul.sv
// alu_mul: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_next;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    // product carries the final iteration so the caller can register it on the done edge
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done       = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign busy       = r_busy;
    assign product    = w_acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            r_busy   <= !done;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; single-cycle ops register in one cycle, MUL iterates in alu_mul.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic [WIDTH-1:0]    dataInACC,
    input  logic [WIDTH-1:0]    dataIn,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    dataOut,
    output logic [3:0]          flags
);
    localparam int MSB = WIDTH - 1;

    state_e           r_state;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_flags;

    op_e               w_op;
    logic              w_accept, w_mul_start, w_mul_busy, w_mul_done;
    logic [WIDTH-1:0]  w_mul_prod, w_res;
    logic [WIDTH:0]    w_sum, w_diff;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic              w_c, w_v, w_big;

    assign w_op        = op_e'(op);
    assign w_accept    = (r_state == ST_IDLE) && in_valid;
    assign w_mul_start = w_accept && (w_op == OP_MUL);
    assign w_sum       = {1'b0, dataInACC} + {1'b0, dataIn};
    assign w_diff      = {1'b0, dataInACC} - {1'b0, dataIn};
    assign w_pc_inc    = pc + PC_WIDTH'(1);
    assign w_big       = dataIn > WIDTH'(WIDTH - 1);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (dataInACC[MSB] == dataIn[MSB]) && (w_sum[MSB] != dataInACC[MSB]);
            end
            OP_NAND: w_res = ~(dataInACC & dataIn);
            OP_BNZ:  w_res = (dataInACC != '0) ? WIDTH'(w_pc_inc) : dataIn;
            OP_SLTU: w_res = WIDTH'(dataInACC < dataIn);
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = !w_diff[WIDTH];
                w_v   = (dataInACC[MSB] != dataIn[MSB]) && (w_diff[MSB] != dataInACC[MSB]);
            end
            OP_SHL:  w_res = w_big ? '0 : dataInACC << dataIn;
            OP_SHR:  w_res = w_big ? '0 : dataInACC >> dataIn;
            default: w_res = '0;
        endcase
    end

    alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (dataInACC),
        .b       (dataIn),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mul_start) begin
                        r_state <= ST_MUL;
                    end else if (w_accept) begin
                        r_data  <= w_res;
                        r_flags <= pack_flags(w_res[MSB], w_v, w_c, w_res == '0);
                        r_state <= ST_DONE;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_data  <= w_mul_prod;
                        r_flags <= pack_flags(w_mul_prod[MSB], 1'b0, 1'b0, w_mul_prod == '0);
                        r_state <= ST_DONE;
                    end else if (!w_mul_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: if (out_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign dataOut   = r_data;
    assign flags     = r_flags;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] pc;
        logic [7:0] res;
        logic [3:0] fl;
    } vec_t;

    localparam vec_t OPS [12] = '{
        '{OP_NAND, 8'hF0, 8'h3C, 8'h00, 8'hCF, 4'b1000},
        '{OP_SLTU, 8'h03, 8'h07, 8'h00, 8'h01, 4'b0000},
        '{OP_SLTU, 8'h07, 8'h03, 8'h00, 8'h00, 4'b0001},
        '{OP_SHR,  8'h80, 8'h03, 8'h00, 8'h10, 4'b0000},
        '{OP_SHL,  8'h81, 8'h01, 8'h00, 8'h02, 4'b0000},
        '{OP_SHR,  8'h80, 8'h08, 8'h00, 8'h00, 4'b0001},
        '{OP_SHL,  8'hFF, 8'h0A, 8'h00, 8'h00, 4'b0001},
        '{OP_ADD,  8'h7F, 8'h01, 8'h00, 8'h80, 4'b1100},
        '{OP_ADD,  8'h80, 8'h80, 8'h00, 8'h00, 4'b0111},
        '{OP_SUB,  8'h03, 8'h05, 8'h00, 8'hFE, 4'b1000},
        '{OP_SUB,  8'h05, 8'h03, 8'h00, 8'h02, 4'b0010},
        '{OP_SUB,  8'h80, 8'h01, 8'h00, 8'h7F, 4'b0110}
    };

    localparam vec_t BNZ [3] = '{
        '{OP_BNZ, 8'h05, 8'h77, 8'h10, 8'h11, 4'b0000},
        '{OP_BNZ, 8'h00, 8'h3C, 8'h10, 8'h3C, 4'b0000},
        '{OP_BNZ, 8'h01, 8'h3C, 8'hFF, 8'h00, 4'b0001}
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv8, ir8, ov8, or8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, pc8, d8;
    logic [3:0]  f8;
    logic        iv16, ir16, ov16, or16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, pc16, d16;
    logic [3:0]  f16;

    int n_tests = 0;
    int n_fail  = 0;

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .dataInACC(a8), .dataIn(b8), .pc(pc8), .out_valid(ov8), .out_ready(or8),
        .dataOut(d8), .flags(f8)
    );

    seq_alu #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .op(op16),
        .dataInACC(a16), .dataIn(b16), .pc(pc16), .out_valid(ov16), .out_ready(or16),
        .dataOut(d16), .flags(f16)
    );

    // called on a falling edge with the unit idle; returns on the falling edge after acceptance
    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] pc);
        iv8 = 1'b1; op8 = op; a8 = a; b8 = b; pc8 = pc;
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        iv16 = 1'b1; op16 = op; a16 = a; b16 = b; pc16 = '0;
        @(negedge clk);
        iv16 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", ov8); end
        n_tests++; if (d8 !== 8'h00) begin n_fail++; $display("FAIL reset_dataOut got=%0h exp=0", d8); end
        n_tests++; if (f8 !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%0h exp=0", f8); end
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", ir8); end
        n_tests++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready16 got=%0h exp=1", ir16); end
    endtask

    task automatic test_add_wrap;
        or8 = 1'b1;
        issue8(OP_ADD, 8'hFF, 8'h01, 8'h00);
        n_tests++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got=%0h exp=1", ov8); end
        n_tests++; if (d8 !== 8'h00) begin n_fail++; $display("FAIL add_dataOut got=%0h exp=0", d8); end
        n_tests++; if (f8 !== 4'b0011) begin n_fail++; $display("FAIL add_flags got=%0h exp=3", f8); end
        @(negedge clk);
        n_tests++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin n_fail++; $display("FAIL add_return_idle got ov=%0h ir=%0h exp ov=0 ir=1", ov8, ir8); end
    endtask

    task automatic test_bnz;
        or8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue8(BNZ[i].op, BNZ[i].a, BNZ[i].b, BNZ[i].pc);
            n_tests++; if (d8 !== BNZ[i].res || f8 !== BNZ[i].fl || ov8 !== 1'b1)
                begin n_fail++; $display("FAIL bnz_%0d got d=%0h f=%0h ov=%0h exp d=%0h f=%0h ov=1", i, d8, f8, ov8, BNZ[i].res, BNZ[i].fl); end
            @(negedge clk);
        end
    endtask

    task automatic test_ops;
        or8 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue8(OPS[i].op, OPS[i].a, OPS[i].b, OPS[i].pc);
            n_tests++; if (d8 !== OPS[i].res || f8 !== OPS[i].fl || ov8 !== 1'b1)
                begin n_fail++; $display("FAIL op_%0d got d=%0h f=%0h ov=%0h exp d=%0h f=%0h ov=1", i, d8, f8, ov8, OPS[i].res, OPS[i].fl); end
            @(negedge clk);
        end
    endtask

    task automatic test_mul;
        int lat;
        or8 = 1'b0;
        issue8(OP_MUL, 8'h0D, 8'h0B, 8'h00);
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (ov8 !== 1'b0 || ir8 !== 1'b0)
                begin n_fail++; $display("FAIL mul_busy_cycle%0d got ov=%0h ir=%0h exp ov=0 ir=0", i + 1, ov8, ir8); end
            if (i == 2) begin iv8 = 1'b1; op8 = OP_ADD; a8 = 8'hFF; b8 = 8'hFF; end
            @(negedge clk);
        end
        n_tests++; if (ov8 !== 1'b1 || d8 !== 8'h8F || f8 !== 4'b1000)
            begin n_fail++; $display("FAIL mul_result got ov=%0h d=%0h f=%0h exp ov=1 d=8f f=8", ov8, d8, f8); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (ov8 !== 1'b1 || ir8 !== 1'b0 || d8 !== 8'h8F || f8 !== 4'b1000)
                begin n_fail++; $display("FAIL mul_hold%0d got ov=%0h ir=%0h d=%0h f=%0h exp ov=1 ir=0 d=8f f=8", i, ov8, ir8, d8, f8); end
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        n_tests++; if (ov8 !== 1'b0 || ir8 !== 1'b1 || d8 !== 8'h8F)
            begin n_fail++; $display("FAIL mul_release got ov=%0h ir=%0h d=%0h exp ov=0 ir=1 d=8f", ov8, ir8, d8); end
        issue8(OP_MUL, 8'hFF, 8'hFF, 8'h00);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_tests++; if (lat + 1 !== 9 || d8 !== 8'h01 || f8 !== 4'b0000)
            begin n_fail++; $display("FAIL mul_wrap got lat=%0d d=%0h f=%0h exp lat=9 d=1 f=0", lat + 1, d8, f8); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        or8 = 1'b1;
        issue8(OP_MUL, 8'h0D, 8'h0B, 8'h00);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++; if (ov8 !== 1'b0 || d8 !== 8'h00 || f8 !== 4'h0 || ir8 !== 1'b1)
            begin n_fail++; $display("FAIL midmul_reset got ov=%0h d=%0h f=%0h ir=%0h exp ov=0 d=0 f=0 ir=1", ov8, d8, f8, ir8); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL midmul_in_ready got=%0h exp=1", ir8); end
        issue8(OP_SLTU, 8'h03, 8'h07, 8'h00);
        n_tests++; if (ov8 !== 1'b1 || d8 !== 8'h01 || f8 !== 4'h0)
            begin n_fail++; $display("FAIL midmul_sltu got ov=%0h d=%0h f=%0h exp ov=1 d=1 f=0", ov8, d8, f8); end
        @(negedge clk);
        issue8(OP_MUL, 8'h03, 8'h05, 8'h00);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_tests++; if (lat + 1 !== 9 || d8 !== 8'h0F)
            begin n_fail++; $display("FAIL midmul_next_mul got lat=%0d d=%0h exp lat=9 d=f", lat + 1, d8); end
        @(negedge clk);
    endtask

    task automatic test_width16;
        int lat;
        or16 = 1'b1;
        issue16(OP_SUB, 16'h8000, 16'h0001);
        n_tests++; if (ov16 !== 1'b1 || d16 !== 16'h7FFF || f16 !== 4'b0110)
            begin n_fail++; $display("FAIL w16_sub got ov=%0h d=%0h f=%0h exp ov=1 d=7fff f=6", ov16, d16, f16); end
        @(negedge clk);
        issue16(OP_SHL, 16'h0001, 16'd16);
        n_tests++; if (d16 !== 16'h0000 || f16 !== 4'b0001)
            begin n_fail++; $display("FAIL w16_shl16 got d=%0h f=%0h exp d=0 f=1", d16, f16); end
        @(negedge clk);
        issue16(OP_SHL, 16'h0001, 16'd15);
        n_tests++; if (d16 !== 16'h8000 || f16 !== 4'b1000)
            begin n_fail++; $display("FAIL w16_shl15 got d=%0h f=%0h exp d=8000 f=8", d16, f16); end
        @(negedge clk);
        issue16(OP_MUL, 16'h1234, 16'h0010);
        lat = 0;
        while (ov16 !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        n_tests++; if (lat + 1 !== 17 || d16 !== 16'h2340 || f16 !== 4'b0000)
            begin n_fail++; $display("FAIL w16_mul got lat=%0d d=%0h f=%0h exp lat=17 d=2340 f=0", lat + 1, d16, f16); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; pc8 = '0;
        iv16 = 1'b0; or16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; pc16 = '0;
        @(negedge clk);
        test_reset;
        test_add_wrap;
        test_bnz;
        test_ops;
        test_mul;
        test_reset_mid_mul;
        test_width16;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data path width (4..32).
REQ-002 SHALL have parameter PC_WIDTH, default WIDTH, program counter width (must be <= WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  operation code, encoding per REQ-014.
REQ-008 SHALL have port dataInACC  input  WIDTH  accumulator operand A.
REQ-009 SHALL have port dataIn  input  WIDTH  operand B.
REQ-010 SHALL have port pc  input  PC_WIDTH  current program counter.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have ports dataOut (output, WIDTH, registered result) and flags (output, 4, {N,V,C,Z}).

Function
REQ-014 SHALL implement the following ops, all modulo 2^WIDTH:
- 000 ADD: A+B.
- 001 NAND: ~(A&B).
- 010 BNZ: A!=0 ? zero-extended pc+1 : B.
- 011 SLTU: A<B unsigned ? 1 : 0.
- 100 SUB: A-B.
- 101 SHL: A << B.
- 110 SHR: A >> B, logical.
- 111 MUL: low WIDTH bits of A*B.
REQ-015 SHALL produce 0 for SHL/SHR when B >= WIDTH.
REQ-016 SHALL use an FSM with states IDLE, MUL, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL, in IDLE with in_valid=1, capture op, A, B and pc. Non-MUL ops: register the result and flags and go to DONE, so out_valid is 1 one cycle after acceptance. MUL: go to MUL.
REQ-018 SHALL compute MUL shift-add, one multiplier bit per cycle, in exactly WIDTH cycles in MUL, then enter DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 SHALL hold dataOut and flags stable in DONE until out_ready=1; on that edge it SHALL return to IDLE. There is no request overlap, so the next acceptance occurs at the earliest one cycle later.
REQ-020 SHALL ignore in_valid and operand changes outside IDLE.
REQ-021 SHALL set flags as follows:
- Z = (result==0).
- N = result MSB.
- C = carry-out for ADD; no-borrow (A>=B) for SUB; else 0.
- V = signed overflow for ADD/SUB; else 0.
REQ-022 SHALL keep dataOut and flags unchanged while in IDLE and MUL (last result persists).

Reset
REQ-023 SHALL, on reset=1 at any time, including mid-MUL, immediately force state=IDLE, dataOut=0, flags=0, out_valid=0 and clear the multiplier accumulator and counter.
REQ-024 SHALL assert in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-025 SHALL place the op encoding enum, FSM state enum and flag bit index constants in shared package alu_pkg.
REQ-026 SHALL implement the iterative multiplier as sub-module alu_mul (start, busy/done, WIDTH-parameterised); all other ops are combinational inside seq_alu.

Verification
REQ-027 WIDTH=8, ADD A=0xFF B=0x01, out_ready=1 -> dataOut=0x00, Z=1, C=1, V=0, out_valid one cycle after accept.
REQ-028 WIDTH=8, BNZ A=0x05 pc=0x10 -> dataOut=0x11. Then BNZ A=0x00 B=0x3C -> dataOut=0x3C.
REQ-029 WIDTH=8, MUL A=0x0D B=0x0B -> dataOut=0x8F, out_valid exactly 9 cycles after accept. With out_ready=0 for 5 cycles: result held, in_ready=0 throughout.
REQ-030 WIDTH=16, SUB A=0x8000 B=0x0001 -> dataOut=0x7FFF, V=1, C=1. SHL A=0x0001 B=16 -> dataOut=0, Z=1.
REQ-031 Reset asserted at MUL cycle 4 -> out_valid=0, dataOut=0 immediately. After release, SLTU A=3 B=7 -> dataOut=1.
